// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the request-handler memory path.
// Used by request_handler and wishbone_mem_responder.
package mem_bus_pkg;
   localparam int          DEF_ADDR_W   = 32;
   localparam int          DEF_DATA_W   = 32;
   localparam logic [31:0] DEF_ERR_DATA = 32'hBAD1_BAD1;

   typedef enum logic {
      IDLE = 1'b0,
      BUS  = 1'b1
   } resp_state_t;
endpackage

// File: rtl/wb_watchdog.sv
// ACK wait counter: expired is high during the LIMIT-th consecutive enabled cycle.
// Zero latency on expired; clear has priority over enable.
module wb_watchdog #(
   parameter int LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && !expired)
         count <= count + 1'b1;
   end

   assign expired = (count == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/wishbone_mem_responder.sv
// Runs one request-handler read/write as a single classic Wishbone cycle; one outstanding, busy holds off requester.
// Zero-wait slave gives 1 busy cycle; WB_TIMEOUT_EN adds an ACK watchdog of TIMEOUT_CYCLES cycles.
module wishbone_mem_responder
   import mem_bus_pkg::*;
#(
   parameter int                ADDR_W         = DEF_ADDR_W,
   parameter int                DATA_W         = DEF_DATA_W,
   parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(DEF_ERR_DATA),
   parameter int                TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                mem_read,
   input  logic                mem_write,
   input  logic [ADDR_W-1:0]   adr_to_mem,
   input  logic [DATA_W-1:0]   data_to_mem,
   input  logic [DATA_W/8-1:0] sel_to_mem,
   output logic                mem_busy,
   output logic [DATA_W-1:0]   data_from_mem,
   output logic                bus_err,
   output logic                wb_cyc_o,
   output logic                wb_stb_o,
   output logic                wb_we_o,
   output logic [ADDR_W-1:0]   wb_adr_o,
   output logic [DATA_W-1:0]   wb_dat_o,
   output logic [DATA_W/8-1:0] wb_sel_o,
   input  logic [DATA_W-1:0]   wb_dat_i,
   input  logic                wb_ack_i,
   input  logic                wb_err_i
);
   resp_state_t state;
   logic        timeout;

`ifdef WB_TIMEOUT_EN
   logic wd_expired;

   wb_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == IDLE),
      .enable  ((state == BUS) && !wb_ack_i && !wb_err_i),
      .expired (wd_expired)
   );

   // An ACK arriving in the final allowed cycle still completes normally.
   assign timeout = (state == BUS) && wd_expired && !wb_ack_i;
`else
   assign timeout = 1'b0;
`endif

   // Bus outputs are the captured request itself, so they read zero whenever idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         mem_busy      <= 1'b0;
         data_from_mem <= '0;
         bus_err       <= 1'b0;
         wb_cyc_o      <= 1'b0;
         wb_stb_o      <= 1'b0;
         wb_we_o       <= 1'b0;
         wb_adr_o      <= '0;
         wb_dat_o      <= '0;
         wb_sel_o      <= '0;
      end else begin
         bus_err <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_read || mem_write) begin
                  state    <= BUS;
                  mem_busy <= 1'b1;
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  wb_we_o  <= mem_write;
                  wb_adr_o <= adr_to_mem;
                  wb_dat_o <= data_to_mem;
                  wb_sel_o <= sel_to_mem;
               end
            end
            BUS: begin
               if (wb_err_i || timeout || wb_ack_i) begin
                  if (!wb_we_o)
                     data_from_mem <= (wb_err_i || timeout) ? ERR_DATA : wb_dat_i;
                  bus_err  <= wb_err_i || timeout;
                  state    <= IDLE;
                  mem_busy <= 1'b0;
                  wb_cyc_o <= 1'b0;
                  wb_stb_o <= 1'b0;
                  wb_we_o  <= 1'b0;
                  wb_adr_o <= '0;
                  wb_dat_o <= '0;
                  wb_sel_o <= '0;
               end
            end
            default: begin
               state    <= IDLE;
               mem_busy <= 1'b0;
               wb_cyc_o <= 1'b0;
               wb_stb_o <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_wishbone_mem_responder.sv
// Directed bench for wishbone_mem_responder; inputs driven and outputs sampled on the falling edge.
// Timeout expectations follow WB_TIMEOUT_EN with TIMEOUT_CYCLES = 8.
module tb_wishbone_mem_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read, mem_write;
   logic [31:0] adr_to_mem, data_to_mem;
   logic [3:0]  sel_to_mem;
   logic        mem_busy;
   logic [31:0] data_from_mem;
   logic        bus_err;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [31:0] wb_adr_o, wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i, wb_err_i;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wishbone_mem_responder #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .mem_read(mem_read), .mem_write(mem_write),
      .adr_to_mem(adr_to_mem), .data_to_mem(data_to_mem), .sel_to_mem(sel_to_mem),
      .mem_busy(mem_busy), .data_from_mem(data_from_mem), .bus_err(bus_err),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   task automatic idle_inputs();
      mem_read = 1'b0; mem_write = 1'b0;
      adr_to_mem = '0; data_to_mem = '0; sel_to_mem = '0;
      wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      checks++;
      if ({mem_busy, bus_err, wb_cyc_o, wb_stb_o, wb_we_o} !== 5'b0 || data_from_mem !== 32'h0 ||
          wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 || wb_sel_o !== 4'h0) begin
         errors++;
         $display("FAIL reset_values: busy=%b err=%b cyc=%b stb=%b we=%b dat=%h adr=%h wdat=%h sel=%h, required all zero",
                  mem_busy, bus_err, wb_cyc_o, wb_stb_o, wb_we_o, data_from_mem, wb_adr_o, wb_dat_o, wb_sel_o);
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_busy !== 1'b0 || wb_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_idle: busy=%b cyc=%b, required 0 0", mem_busy, wb_cyc_o);
      end
   endtask

   task automatic test_read_zero_wait();
      int busy_cycles = 0;
      mem_read = 1'b1; adr_to_mem = 32'h0000_ABCD; sel_to_mem = 4'b1111;
      @(negedge clk);
      idle_inputs();
      checks++;
      if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b110 || wb_adr_o !== 32'h0000_ABCD || wb_sel_o !== 4'hF) begin
         errors++;
         $display("FAIL read_bus_outputs: cyc/stb/we=%b adr=%h sel=%h, required 110 0000abcd f",
                  {wb_cyc_o, wb_stb_o, wb_we_o}, wb_adr_o, wb_sel_o);
      end
      wb_ack_i = 1'b1; wb_dat_i = 32'hABCDE101;
      while (mem_busy && busy_cycles < 50) begin
         busy_cycles++;
         @(negedge clk);
         wb_ack_i = 1'b0;
      end
      checks++;
      if (busy_cycles != 1) begin
         errors++;
         $display("FAIL read_busy_cycles: got %0d, required 1", busy_cycles);
      end
      checks++;
      if (data_from_mem !== 32'hABCDE101 || wb_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL read_data: data=%h cyc=%b, required abcde101 0", data_from_mem, wb_cyc_o);
      end
   endtask

   task automatic test_write_wait3();
      int busy_cycles = 0;
      mem_write = 1'b1; adr_to_mem = 32'h0000_FAB1; data_to_mem = 32'h1234_5678; sel_to_mem = 4'b0011;
      @(negedge clk);
      idle_inputs();
      checks++;
      if (wb_we_o !== 1'b1 || wb_adr_o !== 32'h0000_FAB1 || wb_dat_o !== 32'h1234_5678 || wb_sel_o !== 4'b0011) begin
         errors++;
         $display("FAIL write_bus_outputs: we=%b adr=%h dat=%h sel=%b, required 1 0000fab1 12345678 0011",
                  wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o);
      end
      while (mem_busy && busy_cycles < 50) begin
         busy_cycles++;
         wb_ack_i = (busy_cycles == 4);
         wb_dat_i = 32'hDEAD_0000;
         @(negedge clk);
      end
      wb_ack_i = 1'b0;
      checks++;
      if (busy_cycles != 4) begin
         errors++;
         $display("FAIL write_busy_cycles: got %0d, required 4", busy_cycles);
      end
      checks++;
      if (data_from_mem !== 32'hABCDE101 || bus_err !== 1'b0) begin
         errors++;
         $display("FAIL write_data_kept: data=%h err=%b, required abcde101 0", data_from_mem, bus_err);
      end
   endtask

   task automatic test_simultaneous();
      mem_read = 1'b1; mem_write = 1'b1; adr_to_mem = 32'h0000_0100;
      data_to_mem = 32'hCAFE_F00D; sel_to_mem = 4'b1100;
      @(negedge clk);
      mem_write = 1'b0; adr_to_mem = 32'h0000_0555;
      checks++;
      if (wb_we_o !== 1'b1 || wb_adr_o !== 32'h0000_0100) begin
         errors++;
         $display("FAIL both_strobes_write: we=%b adr=%h, required 1 00000100", wb_we_o, wb_adr_o);
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if (mem_busy !== 1'b1 || wb_adr_o !== 32'h0000_0100 || wb_we_o !== 1'b1) begin
         errors++;
         $display("FAIL request_ignored_in_bus: busy=%b adr=%h we=%b, required 1 00000100 1",
                  mem_busy, wb_adr_o, wb_we_o);
      end
      wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777;
      @(negedge clk);
      wb_ack_i = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_busy !== 1'b0 || wb_cyc_o !== 1'b0 || data_from_mem !== 32'hABCDE101) begin
         errors++;
         $display("FAIL single_cycle_only: busy=%b cyc=%b data=%h, required 0 0 abcde101",
                  mem_busy, wb_cyc_o, data_from_mem);
      end
   endtask

   task automatic test_error();
      mem_read = 1'b1; adr_to_mem = 32'h0000_0200; sel_to_mem = 4'hF;
      @(negedge clk);
      idle_inputs();
      wb_err_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h1111_1111;
      @(negedge clk);
      wb_err_i = 1'b0; wb_ack_i = 1'b0;
      checks++;
      if (data_from_mem !== 32'hBAD1_BAD1 || bus_err !== 1'b1 || mem_busy !== 1'b0) begin
         errors++;
         $display("FAIL error_termination: data=%h err=%b busy=%b, required bad1bad1 1 0",
                  data_from_mem, bus_err, mem_busy);
      end
      @(negedge clk);
      checks++;
      if (bus_err !== 1'b0) begin
         errors++;
         $display("FAIL error_pulse_width: err=%b, required 0", bus_err);
      end
   endtask

   task automatic test_back_to_back();
      mem_read = 1'b1; adr_to_mem = 32'h0000_0010; sel_to_mem = 4'hF;
      @(negedge clk);
      adr_to_mem = 32'h0000_0020;
      wb_ack_i = 1'b1; wb_dat_i = 32'h0101_0101;
      @(negedge clk);
      wb_ack_i = 1'b0;
      checks++;
      if (mem_busy !== 1'b0 || data_from_mem !== 32'h0101_0101) begin
         errors++;
         $display("FAIL b2b_first: busy=%b data=%h, required 0 01010101", mem_busy, data_from_mem);
      end
      @(negedge clk);
      idle_inputs();
      checks++;
      if (mem_busy !== 1'b1 || wb_adr_o !== 32'h0000_0020) begin
         errors++;
         $display("FAIL b2b_second_issue: busy=%b adr=%h, required 1 00000020", mem_busy, wb_adr_o);
      end
      wb_ack_i = 1'b1; wb_dat_i = 32'h0202_0202;
      @(negedge clk);
      wb_ack_i = 1'b0;
      checks++;
      if (mem_busy !== 1'b0 || data_from_mem !== 32'h0202_0202) begin
         errors++;
         $display("FAIL b2b_second: busy=%b data=%h, required 0 02020202", mem_busy, data_from_mem);
      end
   endtask

   task automatic test_reset_mid_bus();
      mem_read = 1'b1; adr_to_mem = 32'h0000_0040; sel_to_mem = 4'hF;
      @(negedge clk);
      idle_inputs();
      checks++;
      if (wb_cyc_o !== 1'b1 || mem_busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_bus_entry: cyc=%b busy=%b, required 1 1", wb_cyc_o, mem_busy);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({wb_cyc_o, wb_stb_o, mem_busy} !== 3'b000) begin
         errors++;
         $display("FAIL async_reset_drop: cyc/stb/busy=%b, required 000", {wb_cyc_o, wb_stb_o, mem_busy});
      end
      wb_ack_i = 1'b1; wb_dat_i = 32'h9999_9999;
      @(negedge clk);
      rst = 1'b0;
      wb_ack_i = 1'b0;
      @(negedge clk);
      checks++;
      if (data_from_mem !== 32'h0 || mem_busy !== 1'b0 || wb_cyc_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_abandon: data=%h busy=%b cyc=%b, required 00000000 0 0",
                  data_from_mem, mem_busy, wb_cyc_o);
      end
   endtask

   task automatic test_timeout();
      int busy_cycles = 0;
      logic saw_err = 1'b0;
      mem_read = 1'b1; adr_to_mem = 32'h0000_0080; sel_to_mem = 4'hF;
      @(negedge clk);
      idle_inputs();
      while (mem_busy && busy_cycles < 150) begin
         busy_cycles++;
         @(negedge clk);
      end
      saw_err = bus_err;
`ifdef WB_TIMEOUT_EN
      checks++;
      if (busy_cycles != 8) begin
         errors++;
         $display("FAIL timeout_cycles: got %0d, required 8", busy_cycles);
      end
      checks++;
      if (data_from_mem !== 32'hBAD1_BAD1 || saw_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_result: data=%h err=%b, required bad1bad1 1", data_from_mem, saw_err);
      end
`else
      checks++;
      if (busy_cycles < 100 || mem_busy !== 1'b1 || saw_err !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout_wait: busy_cycles=%0d busy=%b err=%b, required >=100 1 0",
                  busy_cycles, mem_busy, saw_err);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
`endif
   endtask

   initial begin
      test_reset();
      test_read_zero_wait();
      test_write_wait3();
      test_simultaneous();
      test_error();
      test_back_to_back();
      test_reset_mid_bus();
      test_timeout();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
